// File: rtl/cpu_io_bridge_if.sv
// Handshake bundle between the CPU side, the fabric side and the IO bridge.
// slave = bridge view, master = view of the surrounding CPU/fabric logic.
interface cpu_io_bridge_if #(
  parameter int DATA_W    = 4,
  parameter int NUM_OP    = 2,
  parameter int NUM_RES   = 3,
  parameter int RES_DEPTH = 4
);
  logic                          cpu_op_valid;
  logic                          cpu_op_ready;
  logic [NUM_OP*DATA_W-1:0]      cpu_op_data;
  logic                          fab_op_valid;
  logic                          fab_op_ready;
  logic [NUM_OP*DATA_W-1:0]      fab_op_data;
  logic                          fab_res_valid;
  logic                          fab_res_ready;
  logic [NUM_RES*DATA_W-1:0]     fab_res_data;
  logic                          cpu_res_valid;
  logic                          cpu_res_ready;
  logic [NUM_RES*DATA_W-1:0]     cpu_res_data;
  logic [$clog2(RES_DEPTH):0]    res_count;

  modport slave (
    input  cpu_op_valid, cpu_op_data, fab_op_ready,
    input  fab_res_valid, fab_res_data, cpu_res_ready,
    output cpu_op_ready, fab_op_valid, fab_op_data,
    output fab_res_ready, cpu_res_valid, cpu_res_data, res_count
  );

  modport master (
    output cpu_op_valid, cpu_op_data, fab_op_ready,
    output fab_res_valid, fab_res_data, cpu_res_ready,
    input  cpu_op_ready, fab_op_valid, fab_op_data,
    input  fab_res_ready, cpu_res_valid, cpu_res_data, res_count
  );
endinterface

// File: rtl/cpu_io_bridge.sv
// CPU<->fabric IO bridge: operands via 1-entry register (1 cycle), results via RES_DEPTH FIFO (1 cycle).
// Backpressure: operand ready passes through fab_op_ready when full; result ready drops only when FIFO is full.
module cpu_io_bridge #(
  parameter int DATA_W       = 4,
  parameter int NUM_OP       = 2,
  parameter int NUM_RES      = 3,
  parameter int RES_DEPTH    = 4,
  parameter int NoConfigBits = 2
) (
  input  logic                    UserCLK,
  input  logic                    rst_n,
  input  logic [NoConfigBits-1:0] ConfigBits,
  cpu_io_bridge_if.slave          bus
);
  localparam int OP_W  = NUM_OP * DATA_W;
  localparam int RES_W = NUM_RES * DATA_W;
  localparam int AW    = $clog2(RES_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RES_DEPTH);

  logic op_bypass;
  logic res_bypass;
  assign op_bypass  = ConfigBits[0];
  assign res_bypass = ConfigBits[1];

  // Operand path
  logic            op_full;
  logic [OP_W-1:0] op_q;
  logic            op_in_xfer;
  logic            op_out_xfer;

  assign bus.cpu_op_ready = op_bypass ? bus.fab_op_ready : (!op_full || bus.fab_op_ready);
  assign bus.fab_op_valid = op_bypass ? bus.cpu_op_valid : op_full;
  assign bus.fab_op_data  = op_bypass ? bus.cpu_op_data  : op_q;

  assign op_in_xfer  = bus.cpu_op_valid && bus.cpu_op_ready;
  assign op_out_xfer = op_full && bus.fab_op_ready;

  always_ff @(posedge UserCLK) begin
    if (!rst_n) begin
      op_full <= 1'b0;
      op_q    <= '0;
    end else if (op_bypass) begin
      op_full <= 1'b0;
    end else if (op_in_xfer) begin
      op_q    <= bus.cpu_op_data;
      op_full <= 1'b1;
    end else if (op_out_xfer) begin
      op_full <= 1'b0;
    end
  end

  // Result path
  logic [RES_W-1:0] mem [RES_DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      res_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign fifo_full  = (res_cnt == FULL_CNT);
  assign fifo_empty = (res_cnt == '0);
  // Push qualifies on registered fullness only, so a pop never frees a slot in the same cycle.
  assign push = !res_bypass && bus.fab_res_valid && !fifo_full;
  assign pop  = !res_bypass && bus.cpu_res_ready && !fifo_empty;

  assign bus.fab_res_ready = res_bypass ? bus.cpu_res_ready : !fifo_full;
  assign bus.cpu_res_valid = res_bypass ? bus.fab_res_valid : !fifo_empty;
  assign bus.cpu_res_data  = res_bypass ? bus.fab_res_data  : mem[rd_ptr];
  assign bus.res_count     = res_cnt;

  always_ff @(posedge UserCLK) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      res_cnt <= '0;
      for (int i = 0; i < RES_DEPTH; i++) mem[i] <= '0;
    end else if (res_bypass) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      res_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.fab_res_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   res_cnt <= res_cnt + (AW+1)'(1);
        2'b01:   res_cnt <= res_cnt - (AW+1)'(1);
        default: res_cnt <= res_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed bench for cpu_io_bridge: reset, operand register, result FIFO, bypass, mid-run reset.
module tb_cpu_io_bridge;
  logic       clk;
  logic       rst_n;
  logic [1:0] cfg;
  int         checks;
  int         errors;

  cpu_io_bridge_if #(.DATA_W(4), .NUM_OP(2), .NUM_RES(3), .RES_DEPTH(4)) bus ();

  cpu_io_bridge #(
    .DATA_W(4), .NUM_OP(2), .NUM_RES(3), .RES_DEPTH(4), .NoConfigBits(2)
  ) u_dut (
    .UserCLK    (clk),
    .rst_n      (rst_n),
    .ConfigBits (cfg),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [11:0] sb[$];
  logic [11:0] wdata;
  logic        go;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    cfg   = 2'b00;
    bus.cpu_op_valid  = 1'b0;
    bus.cpu_op_data   = '0;
    bus.fab_op_ready  = 1'b0;
    bus.fab_res_valid = 1'b0;
    bus.fab_res_data  = '0;
    bus.cpu_res_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset / idle
    check("rst_fab_op_valid", bus.fab_op_valid, 0);
    check("rst_fab_op_data", bus.fab_op_data, 0);
    check("rst_cpu_res_valid", bus.cpu_res_valid, 0);
    check("rst_cpu_res_data", bus.cpu_res_data, 0);
    check("rst_res_count", bus.res_count, 0);
    check("rst_cpu_op_ready", bus.cpu_op_ready, 1);
    check("rst_fab_res_ready", bus.fab_res_ready, 1);

    // Operand register: latency and stall
    bus.cpu_op_valid = 1'b1;
    bus.cpu_op_data  = 8'hA5;
    settle();
    check("op_ready_empty", bus.cpu_op_ready, 1);
    check("op_no_fallthrough", bus.fab_op_valid, 0);
    tick();
    bus.cpu_op_data = 8'h3C;
    settle();
    check("op_valid_lat1", bus.fab_op_valid, 1);
    check("op_data_first", bus.fab_op_data, 8'hA5);
    check("op_ready_full", bus.cpu_op_ready, 0);
    tick();
    check("op_stall_data", bus.fab_op_data, 8'hA5);
    check("op_stall_ready", bus.cpu_op_ready, 0);
    bus.fab_op_ready = 1'b1;
    settle();
    check("op_ready_comb", bus.cpu_op_ready, 1);
    tick();
    bus.cpu_op_valid = 1'b0;
    settle();
    check("op_b2b_valid", bus.fab_op_valid, 1);
    check("op_b2b_data", bus.fab_op_data, 8'h3C);
    tick();
    check("op_drained", bus.fab_op_valid, 0);
    check("op_data_hold", bus.fab_op_data, 8'h3C);
    bus.fab_op_ready = 1'b0;

    // Result FIFO fill
    bus.cpu_res_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.fab_res_valid = 1'b1;
      bus.fab_res_data  = 12'(i);
      settle();
      check("fill_ready", bus.fab_res_ready, 1);
      if (i == 1) check("res_no_fallthrough", bus.cpu_res_valid, 0);
      tick();
    end
    check("fill_count", bus.res_count, 4);
    check("fill_full_ready", bus.fab_res_ready, 0);
    check("fill_head", bus.cpu_res_data, 12'h001);
    bus.fab_res_data = 12'h005;
    tick();
    check("refused_count", bus.res_count, 4);
    // Pop while full with a push offered: the push must stay refused
    bus.cpu_res_ready = 1'b1;
    settle();
    check("full_ready_indep", bus.fab_res_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", bus.cpu_res_valid, 1);
      check("drain_data", bus.cpu_res_data, i);
      tick();
      bus.fab_res_valid = 1'b0;
      settle();
    end
    check("drain_count", bus.res_count, 0);
    check("drain_empty", bus.cpu_res_valid, 0);

    // Simultaneous push/pop at count 2 with wrap-around
    bus.cpu_res_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = 12'h100 + 12'(i);
      bus.fab_res_valid = 1'b1;
      bus.fab_res_data  = wdata;
      sb.push_back(wdata);
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      go    = ($urandom_range(0, 3) != 0);
      wdata = 12'($urandom);
      bus.fab_res_valid = go;
      bus.cpu_res_ready = go;
      bus.fab_res_data  = wdata;
      settle();
      check("pp_count", bus.res_count, 2);
      check("pp_valid", bus.cpu_res_valid, 1);
      check("pp_order", bus.cpu_res_data, sb[0]);
      if (go) begin
        void'(sb.pop_front());
        sb.push_back(wdata);
      end
      tick();
    end
    bus.fab_res_valid = 1'b0;
    bus.cpu_res_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("pp_tail", bus.cpu_res_data, sb[0]);
      void'(sb.pop_front());
      tick();
    end
    check("pp_final_count", bus.res_count, 0);
    bus.cpu_res_ready = 1'b0;

    // Bypass both directions
    rst_n = 1'b0;
    cfg   = 2'b11;
    tick();
    rst_n = 1'b1;
    tick();
    bus.cpu_op_valid = 1'b1;
    bus.cpu_op_data  = 8'h5A;
    bus.fab_op_ready = 1'b0;
    bus.fab_res_valid = 1'b1;
    bus.fab_res_data  = 12'hABC;
    settle();
    check("byp_op_valid", bus.fab_op_valid, 1);
    check("byp_op_data", bus.fab_op_data, 8'h5A);
    check("byp_op_ready0", bus.cpu_op_ready, 0);
    check("byp_res_valid", bus.cpu_res_valid, 1);
    check("byp_res_data", bus.cpu_res_data, 12'hABC);
    check("byp_res_ready0", bus.fab_res_ready, 0);
    bus.fab_op_ready  = 1'b1;
    bus.cpu_res_ready = 1'b1;
    bus.cpu_op_data   = 8'hC3;
    settle();
    check("byp_op_ready1", bus.cpu_op_ready, 1);
    check("byp_op_track", bus.fab_op_data, 8'hC3);
    check("byp_res_ready1", bus.fab_res_ready, 1);
    tick();
    check("byp_count", bus.res_count, 0);
    bus.fab_res_valid = 1'b0;
    settle();
    check("byp_res_valid0", bus.cpu_res_valid, 0);
    bus.cpu_op_valid  = 1'b0;
    bus.fab_op_ready  = 1'b0;
    bus.cpu_res_ready = 1'b0;

    // Reset mid-operation
    rst_n = 1'b0;
    cfg   = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    bus.cpu_op_valid = 1'b1;
    bus.cpu_op_data  = 8'h77;
    for (int i = 0; i < 3; i++) begin
      bus.fab_res_valid = 1'b1;
      bus.fab_res_data  = 12'h700 + 12'(i);
      tick();
    end
    bus.cpu_op_valid = 1'b0;
    bus.fab_res_data = 12'hEEE;
    check("mid_count", bus.res_count, 3);
    check("mid_op_full", bus.fab_op_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.fab_res_valid = 1'b0;
    settle();
    check("mrst_count", bus.res_count, 0);
    check("mrst_op_valid", bus.fab_op_valid, 0);
    check("mrst_res_valid", bus.cpu_res_valid, 0);
    check("mrst_op_data", bus.fab_op_data, 0);
    check("mrst_res_data", bus.cpu_res_data, 0);
    bus.fab_op_ready  = 1'b1;
    bus.cpu_res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_res_valid", bus.cpu_res_valid, 0);
      check("post_rst_op_valid", bus.fab_op_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_io_bridge.md
Name: cpu_io_bridge

Overview:
- Parametrised successor to the fixed 4-bit CPU IO pass tile.
- Moves operand words from the CPU into the fabric, and result words from the fabric back to the CPU.
- Both directions use valid/ready handshakes instead of bare wires.
- Operand path is a 1-entry pipeline register; result path is a FIFO that absorbs CPU back-pressure.
- Two configuration bits select legacy combinational pass-through per direction. The block sits at the west edge of the CPU IO tile column.

Parameters:
DATA_W, 4, bits per operand/result lane
NUM_OP, 2, operand lanes (OPA, OPB, ...)
NUM_RES, 3, result lanes
RES_DEPTH, 4, result FIFO entries; power of two, >=2
NoConfigBits, 2, configuration bits consumed

Ports:
UserCLK  in  1  fabric user clock; all state on rising edge
rst_n  in  1  synchronous active-low reset
ConfigBits  in  NoConfigBits  [0]=op_bypass, [1]=res_bypass; static during operation
cpu_op_valid  in  1  CPU offers an operand set
cpu_op_ready  out  1  bridge accepts the operand set
cpu_op_data  in  NUM_OP*DATA_W  operand lanes, lane i at [i*DATA_W +: DATA_W]
fab_op_valid  out  1  operand set available to fabric
fab_op_ready  in  1  fabric consumes the operand set
fab_op_data  out  NUM_OP*DATA_W  operand lanes to fabric
fab_res_valid  in  1  fabric offers a result set
fab_res_ready  out  1  bridge accepts the result set
fab_res_data  in  NUM_RES*DATA_W  result lanes from fabric
cpu_res_valid  out  1  result set available to CPU
cpu_res_ready  in  1  CPU consumes the result set
cpu_res_data  out  NUM_RES*DATA_W  result lanes to CPU
res_count  out  $clog2(RES_DEPTH)+1  result FIFO occupancy

Behaviour:
- Transfer rule: a transfer occurs on an edge where valid & ready are both high. A valid, once asserted, holds with stable data until accepted.
- Reset (rst_n low at an edge):
  - op register empty; fab_op_valid=0; fab_op_data=0.
  - FIFO empty; rd/wr pointers=0; res_count=0; cpu_res_valid=0; cpu_res_data=0.
  - Reset mid-transfer discards held operand and all queued results; no transfer completes on that edge.
- Operand path, op_bypass=0:
  - 1-entry register with flag full.
  - cpu_op_ready = !full | fab_op_ready (combinational from fab_op_ready).
  - On CPU transfer: data captured, full=1.
  - On fabric transfer without CPU transfer: full=0.
  - Both on the same edge: new data replaces old, full stays 1.
  - Latency 1 cycle from CPU transfer to fab_op_valid; throughput 1 set/cycle.
  - fab_op_data holds the last captured value when empty.
- Operand path, op_bypass=1:
  - fab_op_valid=cpu_op_valid, cpu_op_ready=fab_op_ready, fab_op_data=cpu_op_data, all combinational.
  - Register is held empty.
- Result path, res_bypass=0:
  - FIFO of RES_DEPTH entries, wrap-around pointers, count 0..RES_DEPTH.
  - fab_res_ready = (res_count != RES_DEPTH), registered-state based, no dependence on cpu_res_ready. When full, a same-cycle pop does not enable a push.
  - cpu_res_valid = (res_count != 0). cpu_res_data = entry at read pointer, driven from storage. An empty FIFO does no fall-through: latency 1 cycle push to cpu_res_valid.
  - Push only: count+1. Pop only: count-1. Push and pop on the same edge (count between 1 and RES_DEPTH-1): count unchanged, both pointers advance.
  - Pointers wrap modulo RES_DEPTH.
- Result path, res_bypass=1:
  - Combinational pass-through, fab->cpu, mirroring the operand bypass.
  - FIFO held empty; res_count=0.
- Config change: ConfigBits may change only while rst_n=0. Behaviour on a change outside reset is undefined and is not verified.
- Lanes are opaque; no arithmetic on data.

Test Plan:
- Reset then idle, ConfigBits=0 -> all valids 0, res_count=0, cpu_op_ready=1, fab_res_ready=1.
- Operand latency: CPU sends 8'hA5 (OPA=5, OPB=A), fab_op_ready=0 -> fab_op_valid=1 next cycle with data 8'hA5; cpu_op_ready=0; second set 8'h3C stalls until fab_op_ready=1. Then 8'hA5 and 8'h3C are delivered in order, back-to-back.
- FIFO fill/drain: cpu_res_ready=0, push 12'h001..12'h004 -> res_count=4, fab_res_ready=0; fifth push is refused. cpu_res_ready=1 -> 001,002,003,004 in order over 4 cycles; res_count returns to 0.
- Simultaneous push/pop at count=2, 20 random-stall cycles -> count constant on push+pop edges; pointers wrap past 3 with order preserved against a scoreboard.
- Bypass: ConfigBits=2'b11 -> fab_op_data tracks cpu_op_data in the same cycle; cpu_res_valid mirrors fab_res_valid; res_count stays 0.
- Reset mid-operation: 3 results queued and operand register full, rst_n low for one edge -> res_count=0, fab_op_valid=0, cpu_res_valid=0 on the next cycle; no stale data delivered afterwards.
